hazard_controller: RTL

//  Pipeline sequencer for the 5-stage core; works alongside the EX forwarding unit.
//  - Detects load-use hazards forwarding cannot cover and inserts one bubble.
//  - Flushes on taken branch/jump.
//  - Runs the busy-wait FSM for the multi-cycle mult/div unit.
//  - Keeps saturating stall and flush counters for performance debug.

---
 rtl/hazard_controller_pkg.sv | 11 +
 rtl/hazard_controller_if.sv | 36 +++
 rtl/hazard_controller_sat_counter.sv | 19 +
 rtl/hazard_controller.sv | 104 ++++++++++
 4 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared pipeline types for the hazard controller: mult/div FSM states and register constants.
package pipeline_pkg;

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } md_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_controller_if.sv
// Pipeline-to-hazard-controller signal bundle; master is the datapath, slave is the controller.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_IF_ID_Rs;
  logic [4:0]       i_IF_ID_Rt;
  logic             i_ID_uses_Rt;
  logic [4:0]       i_ID_EX_Rt;
  logic             i_ID_EX_mem_read;
  logic             i_ID_md_use;
  logic             i_ID_EX_md_start;
  logic             i_EX_branch_taken;
  logic             i_ID_jump;
  logic             o_PC_write;
  logic             o_IF_ID_write;
  logic             o_IF_ID_flush;
  logic             o_ID_EX_flush;
  logic             o_md_busy;
  logic             o_md_done;
  logic [CNT_W-1:0] o_stall_cycles;
  logic [CNT_W-1:0] o_flush_count;

  modport master (
    output i_IF_ID_Rs, i_IF_ID_Rt, i_ID_uses_Rt, i_ID_EX_Rt, i_ID_EX_mem_read,
           i_ID_md_use, i_ID_EX_md_start, i_EX_branch_taken, i_ID_jump,
    input  o_PC_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_flush,
           o_md_busy, o_md_done, o_stall_cycles, o_flush_count
  );

  modport slave (
    input  i_IF_ID_Rs, i_IF_ID_Rt, i_ID_uses_Rt, i_ID_EX_Rt, i_ID_EX_mem_read,
           i_ID_md_use, i_ID_EX_md_start, i_EX_branch_taken, i_ID_jump,
    output o_PC_write, o_IF_ID_write, o_IF_ID_flush, o_ID_EX_flush,
           o_md_busy, o_md_done, o_stall_cycles, o_flush_count
  );
endinterface

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping; clr has priority over en.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Load-use bubble insertion, branch/jump flush, mult/div busy-wait FSM and saturating perf counters.
// Control outputs are combinational; only the FSM, md_done and the counters are registered.
module hazard_controller
  import pipeline_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  hazard_controller_if.slave bus
);

  // Counter only ever holds MD_LATENCY-1 down to 1.
  localparam int MD_CNT_W = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;

  md_state_t           state, state_nxt;
  logic [MD_CNT_W-1:0] md_cnt, md_cnt_nxt;
  logic                md_done, md_done_nxt;

  logic load_use, md_haz, stall;
  logic pc_write, if_id_write, if_id_flush, id_ex_flush;

  assign load_use = bus.i_ID_EX_mem_read && (bus.i_ID_EX_Rt != REG_ZERO) &&
                    ((bus.i_ID_EX_Rt == bus.i_IF_ID_Rs) ||
                     (bus.i_ID_uses_Rt && (bus.i_ID_EX_Rt == bus.i_IF_ID_Rt)));
  assign md_haz   = ((state == MD_WAIT) || bus.i_ID_EX_md_start) && bus.i_ID_md_use;
  assign stall    = load_use || md_haz;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= RUN;
      md_cnt  <= '0;
      md_done <= 1'b0;
    end else begin
      state   <= state_nxt;
      md_cnt  <= md_cnt_nxt;
      md_done <= md_done_nxt;
    end
  end

  // A start seen while already waiting is ignored; the op in flight keeps its count.
  always_comb begin
    state_nxt   = state;
    md_cnt_nxt  = md_cnt;
    md_done_nxt = 1'b0;
    case (state)
      RUN: begin
        if (bus.i_ID_EX_md_start) begin
          state_nxt  = MD_WAIT;
          md_cnt_nxt = MD_CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_WAIT: begin
        md_cnt_nxt = md_cnt - 1'b1;
        if (md_cnt == MD_CNT_W'(1)) begin
          state_nxt   = RUN;
          md_done_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Taken branch outranks stalls: the stalled ID instruction is squashed anyway.
  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (bus.i_EX_branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
    end else if (bus.i_ID_jump) begin
      if_id_flush = 1'b1;
    end
  end

  assign bus.o_PC_write    = pc_write;
  assign bus.o_IF_ID_write = if_id_write;
  assign bus.o_IF_ID_flush = if_id_flush;
  assign bus.o_ID_EX_flush = id_ex_flush;
  assign bus.o_md_busy     = (state == MD_WAIT);
  assign bus.o_md_done     = md_done;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (i_clk),
    .en  (!pc_write),
    .clr (i_reset),
    .q   (bus.o_stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk (i_clk),
    .en  (if_id_flush),
    .clr (i_reset),
    .q   (bus.o_flush_count)
  );

endmodule
